pwm_dac_multi: RTL and testbench

Multi-channel PWM DAC, the parametrised successor to the single-channel `dac`. It drives NUM_CH PWM outputs from one shared window counter. New code vectors arrive through a one-entry ready/valid holding buffer and are applied atomically at window boundaries. An optional stagger mode phase-offsets the channels to spread switching edges. It sits between the sample source (tone/wave generator or FIFO) and the FPGA audio/LED output pins.

---
 rtl/pwm_dac_multi.sv | 57 +++++
 tb/tb_pwm_dac_multi.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pwm_dac_multi.sv
// pwm_dac_multi: NUM_CH PWM DAC channels sharing one window counter, codes applied atomically at window boundaries
module pwm_dac_multi #(
  parameter int NUM_CH            = 2,
  parameter int CODE_WIDTH        = 10,
  parameter int CYCLES_PER_WINDOW = 1024,
  parameter int STAGGER           = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*CODE_WIDTH-1:0] code_in,
  input  logic                         code_valid,
  output logic                         code_ready,
  output logic [NUM_CH-1:0]            pwm,
  output logic                         next_sample,
  output logic                         underrun
);
  localparam int W  = CYCLES_PER_WINDOW;
  localparam int CW = $clog2(W);
  localparam int MW = (CODE_WIDTH > CW) ? CODE_WIDTH : CW;
  logic [CW-1:0]                cnt;
  logic [NUM_CH*CODE_WIDTH-1:0] act;
  logic [NUM_CH*CODE_WIDTH-1:0] pend_data;
  logic                         pend_valid;
  logic                         boundary;
  logic                         xfer;
  logic [NUM_CH-1:0]            hit;
  assign boundary    = cnt == CW'(W - 1);
  assign next_sample = boundary;
  // the buffer drains at the boundary edge, so it can refill in that same cycle
  assign code_ready  = !pend_valid | boundary;
  assign xfer        = code_valid & code_ready;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int OFF = (STAGGER != 0) ? c * (W / NUM_CH) : 0;
    logic [CW:0]   sum;
    logic [CW-1:0] phase;
    assign sum    = {1'b0, cnt} + (CW+1)'(OFF);
    assign phase  = (sum >= (CW+1)'(W)) ? CW'(sum - (CW+1)'(W)) : sum[CW-1:0];
    assign hit[c] = MW'(phase) < MW'(act[c*CODE_WIDTH +: CODE_WIDTH]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      act        <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      pwm        <= '0;
      underrun   <= 1'b0;
    end else begin
      cnt        <= boundary ? '0 : cnt + CW'(1);
      pwm        <= hit;
      underrun   <= boundary & !pend_valid;
      if (boundary && pend_valid) act <= pend_data;
      if (xfer) pend_data <= code_in;
      pend_valid <= xfer | (pend_valid & !boundary);
    end
  end
endmodule

// File: tb/tb_pwm_dac_multi.sv
// tb_pwm_dac_multi: aligned and staggered instances checked against a window-level model plus directed sequences
module tb_pwm_dac_multi;
  localparam int W = 8;
  localparam int N = 2;
  typedef struct {
    logic [3:0] c0;
    logic [3:0] c1;
    int         h0;
    int         h1;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] code_in = '0;
  logic       code_ready, ready_s, next_sample, ns_s, underrun, un_s;
  logic [1:0] pwm, pwm_s;
  int tests = 0;
  int fails = 0;
  int n;
  int act[2];
  int q[$];
  int e0[2];
  int es[2];
  int eun;
  vec_t tbl[7];
  pwm_dac_multi #(.NUM_CH(N), .CODE_WIDTH(4), .CYCLES_PER_WINDOW(W), .STAGGER(0)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .code_ready(code_ready),
    .pwm(pwm), .next_sample(next_sample), .underrun(underrun));
  pwm_dac_multi #(.NUM_CH(N), .CODE_WIDTH(4), .CYCLES_PER_WINDOW(W), .STAGGER(1)) dut_s (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .code_ready(ready_s),
    .pwm(pwm_s), .next_sample(ns_s), .underrun(un_s));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (n=%0d)", nm, a, e, n);
    end
  endtask
  task automatic check_all();
    int  k = n % W;
    logic rdy = (q.size() == 0) || (k == W - 1);
    chk("pwm", pwm, {e0[1][0], e0[0][0]});
    chk("pwm_stagger", pwm_s, {es[1][0], es[0][0]});
    chk("underrun", underrun, eun);
    chk("underrun_stagger", un_s, eun);
    chk("next_sample", {ns_s, next_sample}, {2{k == W - 1}});
    chk("code_ready", {ready_s, code_ready}, {2{rdy}});
  endtask
  // one clock: the model advances by window rules (queue of pending codes, duty as phase < code)
  task automatic step(input logic v, input logic [7:0] c);
    int  k;
    logic bnd;
    logic rdy;
    code_valid = v;
    code_in    = c;
    @(posedge clk);
    k   = n % W;
    bnd = (k == W - 1);
    rdy = (q.size() == 0) || bnd;
    for (int i = 0; i < N; i++) begin
      e0[i] = (k < act[i]) ? 1 : 0;
      es[i] = (((k + i * W / N) % W) < act[i]) ? 1 : 0;
    end
    eun = (bnd && q.size() == 0) ? 1 : 0;
    if (bnd && q.size() > 0) begin
      int x = q.pop_front();
      act[0] = x % 16;
      act[1] = x / 16;
    end
    if (v && rdy) q.push_back(int'(c));
    n++;
    #1;
    check_all();
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    code_valid = 1'b0;
    #1;
    n = 0;
    act = '{0, 0};
    q.delete();
    e0 = '{0, 0};
    es = '{0, 0};
    eun = 0;
    chk("rst_pwm", {pwm_s, pwm}, 0);
    chk("rst_next_sample", {ns_s, next_sample}, 0);
    chk("rst_code_ready", {ready_s, code_ready}, 2'b11);
    chk("rst_underrun", {un_s, underrun}, 0);
    @(negedge clk) rst = 1'b0;
  endtask
  initial begin
    int h0, h1, hs0, hs1, cu, cp;
    logic hist[$];
    tbl[0] = '{4'd0, 4'd8, 0, 8};
    tbl[1] = '{4'd0, 4'd15, 0, 8};
    tbl[2] = '{4'd3, 4'd3, 3, 3};
    tbl[3] = '{4'd4, 4'd4, 4, 4};
    tbl[4] = '{4'd8, 4'd1, 8, 1};
    tbl[5] = '{4'd7, 4'd0, 7, 0};
    tbl[6] = '{4'd5, 4'd2, 5, 2};
    do_reset();
    for (int j = 1; j <= 16; j++) begin
      step(1'b0, 8'h00);
      chk("ns_period", next_sample, (j % W) == W - 1);
    end
    do_reset();
    step(1'b0, 8'h00);
    step(1'b1, 8'h02);
    for (int j = 0; j < 5; j++) begin
      chk("hs_ready_low", code_ready, 0);
      step(1'b0, 8'h00);
    end
    chk("hs_ready_high", code_ready, 1);
    step(1'b1, 8'h06);
    h0 = 0;
    for (int j = 0; j < W; j++) begin
      step(1'b0, 8'h00);
      h0 += pwm[0];
    end
    chk("hs_window_a", h0, 2);
    h0 = 0;
    for (int j = 0; j < W; j++) begin
      step(1'b0, 8'h00);
      h0 += pwm[0];
    end
    chk("hs_window_b", h0, 6);
    foreach (tbl[r]) begin
      while (n % W != W - 2) step(1'b0, 8'h00);
      step(1'b1, {tbl[r].c1, tbl[r].c0});
      step(1'b0, 8'h00);
      h0 = 0; h1 = 0; hs0 = 0; hs1 = 0;
      hist.delete();
      for (int j = 0; j < 2 * W; j++) begin
        step(1'b0, 8'h00);
        h0 += pwm[0]; h1 += pwm[1]; hs0 += pwm_s[0]; hs1 += pwm_s[1];
        hist.push_back(pwm_s[0]);
        if (tbl[r].c0 == tbl[r].c1 && j >= W / 2) chk("stagger_shift", pwm_s[1], hist[j - W / 2]);
        if (tbl[r].c0 == tbl[r].c1) chk("aligned_edges", pwm[1], pwm[0]);
      end
      chk("tbl_h0", h0, 2 * tbl[r].h0);
      chk("tbl_h1", h1, 2 * tbl[r].h1);
      chk("tbl_hs0", hs0, 2 * tbl[r].h0);
      chk("tbl_hs1", hs1, 2 * tbl[r].h1);
    end
    cu = 0; cp = 0;
    for (int j = 0; j < 3 * W; j++) begin
      step(1'b0, 8'h00);
      cu += underrun;
      cp += pwm[0];
    end
    chk("underrun_count", cu, 3);
    chk("underrun_duty", cp, 15);
    for (int j = 0; j < 400; j++) step(($urandom_range(0, 3) == 0), 8'($urandom));
    do_reset();
    for (int j = 0; j < 300; j++) step(($urandom_range(0, 5) == 0), 8'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
